branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- IF-stage dynamic branch predictor: direct-mapped BHT of 2-bit saturating counters plus BTB (tag + target).
- Combinational lookup on the fetch PC supplies the next-PC choice and the prediction bit; the prediction bit is pipelined to EX as prediction_EX for misprediction detection.
- Updated from resolved EX-stage conditional branches.
- Keeps saturating branch and misprediction counters for performance analysis.

Parameters:
- INDEX_BITS, 6, log2 of entry count (64 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS, tag width; tag = pc[31:INDEX_BITS+2].
- CNT_INIT, 2'b01, counter value after reset and on not-taken allocation (weakly not-taken).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- pc_IF  input  32  fetch PC.
- prediction_IF  output  1  predicted taken (hit && counter[1]).
- hit_IF  output  1  BTB entry valid and tag match.
- target_IF  output  32  predicted next PC: stored target if prediction_IF, else pc_IF+4.
- update_EX  input  1  resolved conditional branch in EX (branch_EX qualified by not-bubble).
- pc_EX  input  32  PC of resolving branch.
- btaken_EX  input  1  actual outcome.
- target_EX  input  32  computed branch target.
- misprediction_EX  input  1  from hazard detection; counted only when update_EX=1.
- branch_count  output  32  resolved branches, saturating at 0xFFFFFFFF.
- mispredict_count  output  32  mispredicted branches, saturating.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset has priority over any same-cycle update.
- Reset values: all valid=0, all counters=CNT_INIT, targets/tags don't-care, both statistic counters=0.
- Lookup (purely combinational, zero latency):
  - Reads entry[pc_IF index].
  - hit_IF=valid && tag==pc_IF tag.
  - prediction_IF=hit_IF && cnt[1].
  - target_IF=prediction_IF ? tgt : pc_IF+4, with 32-bit wraparound (0xFFFFFFFC+4=0).
- Update on a clk edge with update_EX=1 and reset=0; entry is selected by pc_EX index.
- Tag match (valid, same tag):
  - Counter saturating: taken -> min(cnt+1,3); not-taken -> max(cnt-1,0).
  - Taken also rewrites tgt=target_EX.
- Miss (invalid or different tag), allocate/replace unconditionally:
  - valid=1, tag=pc_EX tag, tgt=target_EX.
  - cnt = btaken_EX ? 2'b10 : CNT_INIT.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Same-cycle read/write to the same index: lookup returns the pre-update contents. The write becomes visible on the next cycle; no bypass.
- Statistics, each update_EX edge:
  - branch_count+1 (holds at max).
  - If misprediction_EX, mispredict_count+1 (holds at max).
  - misprediction_EX without update_EX is ignored.
- Pipeline stall: no stall input. The lookup result is recomputed from the held pc_IF. The caller guarantees update_EX is high exactly one cycle per resolved branch (a bubble in EX deasserts it).
- Flush: no internal effect. Wrong-path instructions never reach update_EX.
- X-safety: update_EX=0 leaves the table unchanged regardless of other EX inputs.
- Implementation: register array (not BRAM), because lookup is asynchronous.

Test Plan:
- Reset, then pc_IF=0x104 -> hit_IF=0, prediction_IF=0, target_IF=0x108; both counts=0.
- update_EX with pc_EX=0x104, btaken_EX=1, target_EX=0x040 -> next cycle pc_IF=0x104 gives hit=1, cnt=10, prediction=1, target_IF=0x040.
- Counter walk at 0x104:
  - Two more taken updates -> cnt stays 11.
  - Then three not-taken -> 10,01,00; prediction 1,0,0.
  - A fourth not-taken holds 00.
- Aliasing: after allocating 0x104, update pc_EX=0x204 (same index 1, tag 2) not-taken.
  - pc_IF=0x104 -> hit=0, target 0x108.
  - pc_IF=0x204 -> hit=1, prediction=0.
- Same-cycle read/write: pc_IF=0x104 while updating 0x104 taken from empty -> that cycle hit=0; next cycle hit=1.
- Statistics:
  - 5 update_EX pulses with misprediction_EX=1 on 2 of them, plus one misprediction_EX pulse without update_EX -> branch_count=5, mispredict_count=2.
  - Assert reset during an update_EX cycle -> entry not written, counts=0.

Source files
------------

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: direct-mapped table of 2-bit saturating
// counters with a BTB (tag + target), plus saturating performance counters.
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         TAG_BITS   = 30 - INDEX_BITS,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_IF,
  output logic        prediction_IF,
  output logic        hit_IF,
  output logic [31:0] target_IF,
  input  logic        update_EX,
  input  logic [31:0] pc_EX,
  input  logic        btaken_EX,
  input  logic [31:0] target_EX,
  input  logic        misprediction_EX,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [1:0]          cnt_q [ENTRIES];
  logic [1:0]          cnt_d [ENTRIES];
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_d [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [31:0]         tgt_d [ENTRIES];

  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  ex_match;

  assign if_idx = pc_IF[INDEX_BITS+1:2];
  assign if_tag = pc_IF[31:INDEX_BITS+2];
  assign ex_idx = pc_EX[INDEX_BITS+1:2];
  assign ex_tag = pc_EX[31:INDEX_BITS+2];

  // Word-aligned PCs: the low two bits never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_IF[1:0], pc_EX[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    hit_IF        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    prediction_IF = hit_IF && cnt_q[if_idx][1];
    target_IF     = prediction_IF ? tgt_q[if_idx] : (pc_IF + 32'd4);
  end

  assign ex_match = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (update_EX) begin
      if (ex_match) begin
        if (btaken_EX) begin
          if (cnt_q[ex_idx] != 2'b11) begin
            cnt_d[ex_idx] = cnt_q[ex_idx] + 2'b01;
          end
          tgt_d[ex_idx] = target_EX;
        end else if (cnt_q[ex_idx] != 2'b00) begin
          cnt_d[ex_idx] = cnt_q[ex_idx] - 2'b01;
        end
      end else begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = target_EX;
        cnt_d[ex_idx]   = btaken_EX ? 2'b10 : CNT_INIT;
      end
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_EX) begin
      if (branch_count_q != 32'hFFFF_FFFF) begin
        branch_count_d = branch_count_q + 32'd1;
      end
      if (misprediction_EX && (mispredict_count_q != 32'hFFFF_FFFF)) begin
        mispredict_count_d = mispredict_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q            <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else begin
      valid_q            <= valid_d;
      cnt_q              <= cnt_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural table model predicts each
// cycle's lookup and statistics; a negedge monitor pops and compares.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_IF;
  logic        prediction_IF;
  logic        hit_IF;
  logic [31:0] target_IF;
  logic        update_EX;
  logic [31:0] pc_EX;
  logic        btaken_EX;
  logic [31:0] target_EX;
  logic        misprediction_EX;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .reset            (reset),
    .pc_IF            (pc_IF),
    .prediction_IF    (prediction_IF),
    .hit_IF           (hit_IF),
    .target_IF        (target_IF),
    .update_EX        (update_EX),
    .pc_EX            (pc_EX),
    .btaken_EX        (btaken_EX),
    .target_EX        (target_EX),
    .misprediction_EX (misprediction_EX),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic [31:0] tgt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per table slot, plain integers for counters.
  bit          m_valid [64];
  longint      m_tagv  [64];
  int          m_cnt   [64];
  logic [31:0] m_tgt   [64];
  longint      m_bc, m_mc;
  bit          m_known = 1'b0;

  localparam longint SAT_MAX = 64'h0000_0000_FFFF_FFFF;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((longint'(pc) / 4) % 64);
  endfunction

  function automatic longint tag_of(input logic [31:0] pc);
    return longint'(pc) / 256;
  endfunction

  function automatic exp_t model_expect(input logic [31:0] pc);
    exp_t e;
    int   s;
    s      = slot_of(pc);
    e.pc   = pc;
    e.hit  = m_valid[s] && (m_tagv[s] == tag_of(pc));
    e.pred = e.hit && (m_cnt[s] >= 2);
    e.tgt  = e.pred ? m_tgt[s] : 32'(longint'(pc) + 4);
    e.bc   = 32'(m_bc);
    e.mc   = 32'(m_mc);
    return e;
  endfunction

  task automatic model_step(input logic rst, input logic upd, input logic [31:0] pcex,
                            input logic bt, input logic [31:0] tex, input logic mis);
    int s;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 1;
      end
      m_bc    = 0;
      m_mc    = 0;
      m_known = 1'b1;
    end else if (upd) begin
      s = slot_of(pcex);
      if (m_valid[s] && m_tagv[s] == tag_of(pcex)) begin
        if (bt) begin
          m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
          m_tgt[s] = tex;
        end else begin
          m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
        end
      end else begin
        m_valid[s] = 1'b1;
        m_tagv[s]  = tag_of(pcex);
        m_tgt[s]   = tex;
        m_cnt[s]   = bt ? 2 : 1;
      end
      m_bc = (m_bc + 1 > SAT_MAX) ? SAT_MAX : m_bc + 1;
      if (mis) m_mc = (m_mc + 1 > SAT_MAX) ? SAT_MAX : m_mc + 1;
    end
  endtask

  task automatic cycle(input logic rst, input logic [31:0] pcif, input logic upd,
                       input logic [31:0] pcex, input logic bt, input logic [31:0] tex,
                       input logic mis);
    reset            = rst;
    pc_IF            = pcif;
    update_EX        = upd;
    pc_EX            = pcex;
    btaken_EX        = bt;
    target_EX        = tex;
    misprediction_EX = mis;
    if (m_known) sb_q.push_back(model_expect(pcif));
    @(posedge clk);
    #1;
    model_step(rst, upd, pcex, bt, tex, mis);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req,
                       input logic [31:0] pc);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s pc_IF=%08h actual=%08h required=%08h", name, pc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("hit_IF", {31'd0, hit_IF}, {31'd0, e.hit}, e.pc);
      check("prediction_IF", {31'd0, prediction_IF}, {31'd0, e.pred}, e.pc);
      check("target_IF", target_IF, e.tgt, e.pc);
      check("branch_count", branch_count, e.bc, e.pc);
      check("mispredict_count", mispredict_count, e.mc, e.pc);
      $display("t=%0t pc_IF=%08h hit=%0b pred=%0b target=%08h bc=%0d mc=%0d",
               $time, e.pc, hit_IF, prediction_IF, target_IF, branch_count, mispredict_count);
    end
  end

  initial begin
    logic [31:0] pool [8];
    logic [31:0] pa, pb;
    pool = '{32'h0000_0104, 32'h0000_0204, 32'h0000_0108, 32'h0000_0304,
             32'h0000_0208, 32'h0000_010C, 32'hFFFF_FFFC, 32'h0000_0000};

    cycle(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Empty table lookup, then same-cycle read/write of the entry being allocated.
    cycle(1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h104, 1'b1, 32'h104, 1'b1, 32'h40, 1'b0);
    cycle(1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Counter walk: saturate high, then walk down and hold at strong not-taken.
    repeat (2) cycle(1'b0, 32'h104, 1'b1, 32'h104, 1'b1, 32'h40, 1'b0);
    repeat (4) cycle(1'b0, 32'h104, 1'b1, 32'h104, 1'b0, 32'h40, 1'b0);
    cycle(1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h104, 1'b1, 32'h104, 1'b1, 32'h40, 1'b0);
    repeat (2) cycle(1'b0, 32'h104, 1'b1, 32'h104, 1'b1, 32'h44, 1'b0);
    // Aliasing: same index, different tag replaces the entry.
    cycle(1'b0, 32'h104, 1'b1, 32'h204, 1'b0, 32'h80, 1'b0);
    cycle(1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h204, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Wraparound of the fall-through PC.
    cycle(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Statistics: five updates, two mispredicted, one stray misprediction pulse.
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 32'h10, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h404, 1'b0, 32'h10, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h408, 1'b1, 32'h10, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h408, 1'b1, 32'h10, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h40C, 1'b0, 32'h10, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h410, 1'b1, 32'h10, 1'b0);
    cycle(1'b0, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Reset wins over a same-cycle update.
    cycle(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h80, 1'b1);
    cycle(1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Randomized traffic over a small aliasing address pool.
    for (int n = 0; n < 300; n++) begin
      pa = pool[$urandom_range(0, 7)];
      pb = pool[$urandom_range(0, 7)];
      cycle(1'b0, pa, 1'($urandom_range(0, 1)), pb, 1'($urandom_range(0, 1)),
            $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
    end
    cycle(1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
